// File: rtl/inst_encoder_pkg.sv
// Shared RV32I opcode constants, instruction format codes and encoder helpers.
// Used by the inst_encoder top and its inst_pack field packer.
package inst_encoder_pkg;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;

    // addi x0,x0,0: emitted in place of anything that cannot be encoded
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_ARITH:                        f = FMT_R;
            OP_ARITH_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                        f = FMT_S;
            OP_BRANCH:                       f = FMT_B;
            OP_JAL:                          f = FMT_J;
            OP_LUI, OP_AUIPC:                f = FMT_U;
            default:                         f = FMT_BAD;
        endcase
        return f;
    endfunction

    // True when v is representable as a two's-complement number of 'bits' bits
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the instruction encoder.
// master = producer/sink side, slave = encoder side.
interface inst_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready,
        input  out_valid, out_inst, out_addr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready,
        output out_valid, out_inst, out_addr, out_err, err_count
    );

endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I field packer: decoded fields + immediate -> 32-bit word and error flag.
// Defining IMM_RANGE_CHECK_EN also flags immediates that do not fit their format.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    fmt_e fmt;
    logic range_err;

    assign fmt = opcode_fmt(opcode);

    always_comb begin
        inst = NOP_INST;
        case (fmt)
            FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_U: inst = {imm[31:12], rd, opcode};
            default: inst = NOP_INST;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Out-of-range words are still emitted (truncated) so the stream stays aligned
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = !fits_signed(imm, 12);
            FMT_B:        range_err = !fits_signed(imm, 13) || imm[0];
            FMT_J:        range_err = !fits_signed(imm, 21) || imm[0];
            FMT_U:        range_err = (imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = (fmt == FMT_BAD) || range_err;

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with output byte-address counter.
// Optional macro IMM_RANGE_CHECK_EN flags immediates that overflow their format.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    inst_encoder_if.slave  bus
);

    logic [31:0]       pack_inst;
    logic              pack_err;

    logic              s1_valid_reg;
    logic [31:0]       s1_inst_reg;
    logic              s1_err_reg;

    logic              out_valid_reg;
    logic [31:0]       out_inst_reg;
    logic              out_err_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [7:0]        err_count_reg;

    logic              out_adv;
    logic              s1_adv;
    logic              in_ready_int;
    logic              accept;
    logic              handshake;

    inst_pack u_pack (
        .opcode (bus.in_opcode),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .funct3 (bus.in_funct3),
        .funct7 (bus.in_funct7),
        .imm    (bus.in_imm),
        .inst   (pack_inst),
        .err    (pack_err)
    );

    // in_ready depends only on registered state and out_ready, never on in_valid
    assign out_adv      = !out_valid_reg || bus.out_ready;
    assign s1_adv       = s1_valid_reg && out_adv;
    assign in_ready_int = !s1_valid_reg || out_adv;
    assign accept       = bus.in_valid && in_ready_int;
    assign handshake    = out_valid_reg && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_inst_reg  <= '0;
            s1_err_reg   <= 1'b0;
        end else if (clear) begin
            s1_valid_reg <= 1'b0;
        end else begin
            if (in_ready_int) begin
                s1_valid_reg <= bus.in_valid;
            end
            if (accept) begin
                s1_inst_reg <= pack_inst;
                s1_err_reg  <= pack_err;
            end
        end
    end

    // Output register: data only changes when the presented word is taken or absent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_inst_reg  <= '0;
            out_err_reg   <= 1'b0;
            out_addr_reg  <= BASE_ADDR;
        end else if (clear) begin
            out_valid_reg <= 1'b0;
            out_addr_reg  <= BASE_ADDR;
        end else begin
            if (out_adv) begin
                out_valid_reg <= s1_valid_reg;
            end
            if (s1_adv) begin
                out_inst_reg <= s1_inst_reg;
                out_err_reg  <= s1_err_reg;
            end
            if (handshake) begin
                out_addr_reg <= out_addr_reg + ADDR_W'(4);
            end
        end
    end

    // A handshake coinciding with clear is discarded, so it is not counted either
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_reg <= 8'd0;
        end else if (!clear && handshake && out_err_reg && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_inst  = out_inst_reg;
    assign bus.out_err   = out_err_reg;
    assign bus.out_addr  = out_addr_reg;
    assign bus.err_count = err_count_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table through a scoreboard plus
// hand-written latency, backpressure, clear and mid-stream reset sequences.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic clear;

    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(32)) bus ();

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr = 32'h0;
    int          exp_errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.name = nm; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
        return v;
    endfunction

    // Output monitor / scoreboard consumer; samples on the falling edge
    always @(negedge clk) begin
        if (reset || clear) begin
            sb.delete();
            exp_addr = 32'h0;
            if (reset) exp_errs = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h expected=none", bus.out_inst);
            end else begin
                e = sb.pop_front();
                $display("txn %s addr=%h inst=%h err=%0d", e.name, bus.out_addr, bus.out_inst, bus.out_err);
                chk({e.name, "_inst"}, bus.out_inst, e.inst);
                chk({e.name, "_addr"}, bus.out_addr, exp_addr);
                chk({e.name, "_err"}, 32'(bus.out_err), 32'(e.err));
                if (e.err && exp_errs < 255) exp_errs++;
            end
            exp_addr = exp_addr + 32'd4;
        end
    end

    task automatic drive(input vec_t v);
        bus.in_opcode = v.op;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_funct3 = v.f3;
        bus.in_funct7 = v.f7;
        bus.in_imm    = v.imm;
        bus.in_valid  = 1'b1;
    endtask

    task automatic push(input vec_t v);
        exp_t x;
        x.name = v.name; x.inst = v.exp_inst; x.err = v.exp_err;
        sb.push_back(x);
    endtask

    // Presents v until accepted; returns just after the accepting edge with in_valid still high
    task automatic send(input vec_t v);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        drive(v);
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready && !clear) begin
                push(v);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout %s actual=in_ready_low expected=accept", v.name);
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int idx;
        vec_t bp[3];

        reset = 1'b1;
        clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
        bus.out_ready = 1'b1;

        vecs.push_back(mk("addi5",    7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005, 32'h0050_0093, 1'b0));
        vecs.push_back(mk("sw",       7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0));
        vecs.push_back(mk("beq_m4",   7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0));
        vecs.push_back(mk("jal2048",  7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0));
        vecs.push_back(mk("addi4096", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_0093, RC));
        vecs.push_back(mk("lui",      7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0));
        vecs.push_back(mk("auipc",    7'b0010111, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F197, 1'b0));
        vecs.push_back(mk("sub",      7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0));
        vecs.push_back(mk("lw_m8",    7'b0000011, 5'd4, 5'd2, 5'd7, 3'd2, 7'h7F, 32'hFFFF_FFF8, 32'hFF81_2203, 1'b0));
        vecs.push_back(mk("jalr",     7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_8067, 1'b0));
        vecs.push_back(mk("bad_op",   7'b1111111, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h0000_0005, 32'h0000_0013, 1'b1));
        vecs.push_back(mk("sw_m1",    7'b0100011, 5'd9, 5'd4, 5'd3, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'hFE32_2FA3, 1'b0));
        vecs.push_back(mk("bne16",    7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'h0000_0010, 32'h0020_9863, 1'b0));
        vecs.push_back(mk("j_m8",     7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFF8, 32'hFF9F_F06F, 1'b0));
        vecs.push_back(mk("beq_odd",  7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0163, RC));
        vecs.push_back(mk("lui_low",  7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001, 32'h0000_10B7, RC));
        vecs.push_back(mk("addi_max", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 32'h7FF0_0093, 1'b0));
        vecs.push_back(mk("addi_min", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0));
        vecs.push_back(mk("jal_max",  7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0));
        vecs.push_back(mk("jal_over", 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_006F, RC));
        vecs.push_back(mk("sb_over",  7'b0100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0023, RC));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst",  bus.out_inst, 32'h0);
        chk("rst_out_addr",  bus.out_addr, 32'h0);
        chk("rst_out_err",   32'(bus.out_err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: accept at edge N, out_valid visible only after edge N+1
        send(vecs[0]);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge_n", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge_n1", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 1; i < vecs.size(); i++) send(vecs[i]);
        drain();
        @(negedge clk);
        chk("err_count", 32'(bus.err_count), 32'(exp_errs));
        @(posedge clk);
        #1;

        // Backpressure: restart addresses, stall the sink, hold three bundles
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        bp[0] = vecs[1]; bp[1] = vecs[2]; bp[2] = vecs[3];
        bus.out_ready = 1'b0;
        accepted = 0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(bp[idx]);
            @(negedge clk);
            if (c >= 2) chk("bp_hold_inst", bus.out_inst, bp[0].exp_inst);
            if (bus.in_ready) begin
                push(bp[idx]);
                accepted++;
                if (idx < 2) idx++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 32'(accepted), 32'd2);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_no_gap", 32'(bus.out_valid), 32'd1);
            if (c == 0) begin
                chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
                if (bus.in_ready) push(bp[2]);
            end
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
        drain();

        // Clear with two words in flight; the clear-cycle bundle is discarded
        send(vecs[5]);
        send(vecs[6]);
        clear = 1'b1;
        drive(vecs[7]);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_out_addr",  bus.out_addr, 32'h0);
        chk("clr_err_kept",  32'(bus.err_count), 32'(exp_errs));
        @(negedge clk);
        chk("clr_s1_flushed", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(vecs[9]);
        drain();

        // Asynchronous reset mid-stream discards everything in flight
        send(vecs[10]);
        send(vecs[11]);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_out_addr",  bus.out_addr, 32'h0);
        chk("mrst_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        chk("mrst_s1_flushed", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(vecs[12]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the immediate generator. It packs decoded fields (opcode, registers, functs, signed immediate) into a 32-bit instruction word.
- Used by the testbench program loader and self-modifying-test infrastructure to fill instruction memory.
- Two-stage valid/ready pipeline. The output address counter tracks where each emitted word belongs.

Parameters:
- ADDR_W, 32, width of the out_addr counter.
- BASE_ADDR, 0, reset and clear value of out_addr.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush: drops in-flight words, reloads address
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  7  opcode constant
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7
- in_imm  in  32  signed byte offset or value; for U-type, the full 32-bit value
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts the word
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_inst
- out_err  out  1  word flagged invalid
- err_count  out  8  saturating count of emitted flagged words

Behaviour:
- Reset (async) values: out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_err=0, err_count=0, S1 valid=0.
- Opcode to format mapping:
  - ARITHMETIC: R-type, funct7 used, imm ignored.
  - ARITHMETIC_IMM, LOAD, JALR: I-type, imm[11:0] placed in inst[31:20].
  - STORE: S-type, imm[11:5] in inst[31:25], imm[4:0] in inst[11:7].
  - BRANCH: B-type, imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7].
  - JAL: J-type, imm[20|10:1|11|19:12] in inst[31:12].
  - LUI, AUIPC: U-type, imm[31:12] in inst[31:12].
  - Any other opcode: emits NOP 32'h00000013 with out_err=1.
- Fields unused by a format are written as 0 (e.g. rs2 for I-type, funct7 for anything other than R-type).
- Pipeline:
  - S1 registers the encoded word and its error bit.
  - The output register holds the presented word.
  - out_adv = !out_valid || out_ready
  - s1_adv = s1_valid && out_adv
  - in_ready = !s1_valid || out_adv. This is combinational from registered state and out_ready; it never depends on in_valid.
- Latency: a bundle accepted at edge N gives out_valid=1 after edge N+1 when there is no backpressure.
- Ordering and stalls:
  - Words emit in acceptance order, with no loss or duplication under any out_ready pattern.
  - out_inst, out_addr and out_err hold stable while out_valid && !out_ready.
  - Throughput is 1 word per cycle when out_ready=1.
- Address: out_addr is the address of the currently presented word. It increments by 4 after each out_valid && out_ready handshake and wraps modulo 2^ADDR_W.
- err_count increments on a handshake of a word with out_err=1 and saturates at 255.
- clear:
  - On the next edge: S1 valid=0, out_valid=0, out_addr=BASE_ADDR. err_count is kept.
  - clear has priority over a simultaneous input accept or output handshake; the clear-cycle accept is discarded.
- Reset asserted mid-stream discards all in-flight words.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: out_err=1 (word still encoded, truncated) when any of the following holds:
  - I/S imm is outside -2048..2047.
  - B imm is outside -4096..4094, or imm[0]=1.
  - J imm is outside -1048576..1048574, or imm[0]=1.
  - U imm[11:0] is not zero.
- Undefined: no range checks; immediates are silently truncated and out_err is set only for an unknown opcode.

Decomposition:
- Add format codes (FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD) and NOP_INST to the shared opcodes.v constants alongside the existing opcode macros.
- One combinational sub-module inst_pack (opcode, fields, imm in; inst, err out) sits between the input port and the S1 register.

Test Plan:
- addi x1,x0,5 (opcode 0010011, rd=1, funct3=0, imm=5) with out_ready=1 -> out_inst=32'h00500093, out_addr=0, out_err=0, out_valid two edges after accept.
- sw x2,8(x1) (0100011, funct3=010, rs1=1, rs2=2, imm=8), then beq x0,x0,-4 (1100011, imm=-4) -> 32'h0020A423 at addr 0, then 32'hFE000EE3 at addr 4.
- jal x1,2048 (1101111, rd=1, imm=32'h800) -> 32'h001000EF.
- addi x1,x0,4096 -> with the macro: out_inst=32'h00000093, out_err=1, err_count=1. Without it: same word, out_err=0, err_count=0.
- out_ready=0 for 5 cycles with in_valid held on 3 bundles -> exactly 2 accepted, then in_ready=0. After release, 3 words emit in order at addrs 0, 4, 8 with no gap.
- Pulse clear while 2 words are in flight -> out_valid=0 next cycle, out_addr=0. The next accepted word emits at addr 0.
